// File: rtl/pacman_map_writer.sv
// Map RAM writer for pacman moves: reads the tile at the proposed cell, reports it,
// and for legal moves erases the current cell, draws the next one and counts pills.
module pacman_map_writer #(
   parameter int MAP_W  = 40,
   parameter int MAP_H  = 30,
   parameter int ADDR_W = 11,
   parameter int PILL_W = 33
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              ready,
   input  logic [5:0]        curr_x,
   input  logic [4:0]        curr_y,
   input  logic [5:0]        next_x,
   input  logic [4:0]        next_y,
   output logic [3:0]        collision_type,
   output logic              done,
   output logic [PILL_W-1:0] pill_count,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [3:0]        rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [3:0]        wr_data
);

   typedef enum logic [2:0] {
      IDLE, RD, RD_DATA, SETTLE, ERASE, DRAW, DONE, WAIT_LOW
   } state_t;

   localparam logic [3:0] T_EMPTY  = 4'd0;
   localparam logic [3:0] T_WALL   = 4'd1;
   localparam logic [3:0] T_PILL   = 4'd2;
   localparam logic [3:0] T_PACMAN = 4'd3;

   state_t              r_state, w_state_nxt;
   logic [3:0]          r_ct;
   logic [PILL_W-1:0]   r_pill;
   logic [ADDR_W-1:0]   w_addr_curr, w_addr_next;
   logic                w_oob, w_null;

   // Address arithmetic stays ADDR_W wide so oversize products truncate.
   function automatic logic [ADDR_W-1:0] f_addr(input logic [5:0] x, input logic [4:0] y);
      return ADDR_W'(y) * ADDR_W'(MAP_W) + ADDR_W'(x);
   endfunction

   assign w_addr_curr = f_addr(curr_x, curr_y);
   assign w_addr_next = f_addr(next_x, next_y);
   assign w_oob       = (32'(next_x) >= MAP_W) || (32'(next_y) >= MAP_H);
   assign w_null      = (next_x == curr_x) && (next_y == curr_y);

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= IDLE;
         r_ct    <= T_EMPTY;
         r_pill  <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            RD_DATA:  r_ct <= w_oob ? T_WALL : rd_data;
            WAIT_LOW: r_ct <= T_EMPTY;
            DRAW:     if (r_ct == T_PILL) r_pill <= r_pill + PILL_W'(1);
            default:  ;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      rd_addr     = '0;
      wr_en       = 1'b0;
      wr_addr     = '0;
      wr_data     = T_EMPTY;
      done        = 1'b0;
      case (r_state)
         IDLE:     if (ready) w_state_nxt = RD;
         RD: begin
            rd_addr     = w_addr_next;
            w_state_nxt = RD_DATA;
         end
         RD_DATA:  w_state_nxt = SETTLE;
         SETTLE:   w_state_nxt = (r_ct == T_WALL || w_null) ? DONE : ERASE;
         ERASE: begin
            wr_en       = 1'b1;
            wr_addr     = w_addr_curr;
            wr_data     = T_EMPTY;
            w_state_nxt = DRAW;
         end
         DRAW: begin
            wr_en       = 1'b1;
            wr_addr     = w_addr_next;
            wr_data     = T_PACMAN;
            w_state_nxt = DONE;
         end
         DONE: begin
            done        = 1'b1;
            w_state_nxt = WAIT_LOW;
         end
         WAIT_LOW: if (!ready) w_state_nxt = IDLE;
         default:  w_state_nxt = IDLE;
      endcase
   end

   assign collision_type = r_ct;
   assign pill_count     = r_pill;

endmodule

// File: tb/tb_pacman_map_writer.sv
// Directed bench for pacman_map_writer with a behavioural 1-cycle-latency map RAM.
module tb_pacman_map_writer;
   localparam int ADDR_W = 11;
   localparam int PILL_W = 33;

   logic              CLOCK_50 = 1'b0;
   logic              reset, ready;
   logic [5:0]        curr_x, next_x;
   logic [4:0]        curr_y, next_y;
   logic [3:0]        collision_type, rd_data, wr_data;
   logic              done, wr_en;
   logic [PILL_W-1:0] pill_count;
   logic [ADDR_W-1:0] rd_addr, wr_addr;

   logic [3:0]        mem [0:2047];
   logic              tb_we = 1'b0;
   logic [ADDR_W-1:0] tb_wa = '0;
   logic [3:0]        tb_wd = '0;

   int total = 0, bad = 0;
   logic [31:0] ct_l [0:15], done_l [0:15], wen_l [0:15], wa_l [0:15], wd_l [0:15], rd_l [0:15], pill_l [0:15];
   int n_done, n_wen, n_rd;

   pacman_map_writer dut (
      .CLOCK_50(CLOCK_50), .reset(reset), .ready(ready),
      .curr_x(curr_x), .curr_y(curr_y), .next_x(next_x), .next_y(next_y),
      .collision_type(collision_type), .done(done), .pill_count(pill_count),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) begin
      rd_data <= mem[rd_addr];
      if (tb_we)      mem[tb_wa]   <= tb_wd;
      else if (wr_en) mem[wr_addr] <= wr_data;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
   endtask

   task automatic poke(input int a, input logic [3:0] d);
      tb_we = 1'b1; tb_wa = ADDR_W'(a); tb_wd = d;
      step();
      tb_we = 1'b0;
   endtask

   // Run one move: log the cycle after edge k into slot k; optionally turn the
   // move into a null move once collision_type is out (SETTLE cycle).
   task automatic run_move(input int cx, input int cy, input int nx, input int ny, input bit swap);
      curr_x = 6'(cx); curr_y = 5'(cy); next_x = 6'(nx); next_y = 5'(ny);
      ready = 1'b1;
      n_done = 0; n_wen = 0; n_rd = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         ct_l[k] = 32'(collision_type); done_l[k] = 32'(done); wen_l[k] = 32'(wr_en);
         wa_l[k] = 32'(wr_addr); wd_l[k] = 32'(wr_data); rd_l[k] = 32'(rd_addr);
         pill_l[k] = 32'(pill_count);
         n_done += int'(done); n_wen += int'(wr_en); n_rd += int'(rd_addr != '0);
         if (swap && k == 2) begin next_x = curr_x; next_y = curr_y; end
      end
      ready = 1'b0;
      step();
      step();
   endtask

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 4'd0;
      reset = 1'b1; ready = 1'b0;
      curr_x = '0; curr_y = '0; next_x = '0; next_y = '0;
      step();
      chk("rst_ct", collision_type, 0);
      chk("rst_done", done, 0);
      chk("rst_pill", pill_count, 0);
      chk("rst_wen", wr_en, 0);
      chk("rst_waddr", wr_addr, 0);
      chk("rst_wdata", wr_data, 0);
      chk("rst_raddr", rd_addr, 0);
      step();
      reset = 1'b0;

      // Legal move onto an empty cell: (20,20)=820 -> (20,19)=780
      poke(820, 4'd3); poke(780, 4'd0);
      run_move(20, 20, 20, 19, 1'b0);
      chk("m1_rdaddr", rd_l[0], 780);
      chk("m1_ct", ct_l[2], 0);
      chk("m1_erase_en", wen_l[3], 1);
      chk("m1_erase_addr", wa_l[3], 820);
      chk("m1_erase_data", wd_l[3], 0);
      chk("m1_draw_en", wen_l[4], 1);
      chk("m1_draw_addr", wa_l[4], 780);
      chk("m1_draw_data", wd_l[4], 3);
      chk("m1_done_early", done_l[4], 0);
      chk("m1_done", done_l[5], 1);
      chk("m1_done_once", n_done, 1);
      chk("m1_pill", pill_l[5], 0);
      chk("m1_wen_cnt", n_wen, 2);
      chk("m1_ram_next", mem[780], 3);
      chk("m1_ram_curr", mem[820], 0);

      // Same move onto a pill
      poke(820, 4'd3); poke(780, 4'd2);
      run_move(20, 20, 20, 19, 1'b0);
      chk("m2_ct", ct_l[2], 2);
      chk("m2_pill_draw", pill_l[4], 0);
      chk("m2_pill_done", pill_l[5], 1);
      chk("m2_done", done_l[5], 1);
      chk("m2_wen_cnt", n_wen, 2);

      // Wall at (21,20)=821; next is pulled back to curr during SETTLE
      poke(821, 4'd1);
      run_move(20, 20, 21, 20, 1'b1);
      chk("m3_ct", ct_l[2], 1);
      chk("m3_done", done_l[3], 1);
      chk("m3_done_once", n_done, 1);
      chk("m3_no_wen", n_wen, 0);
      chk("m3_ct_cleared", collision_type, 0);
      chk("m3_wall_kept", mem[821], 1);

      // Out of range (45,3): RAM word at 165 holds a pill that must be ignored
      poke(165, 4'd2);
      run_move(20, 20, 45, 3, 1'b0);
      chk("m4_ct", ct_l[2], 1);
      chk("m4_done", done_l[3], 1);
      chk("m4_no_wen", n_wen, 0);
      chk("m4_pill", pill_count, 1);

      // Passable code 7 is reported unchanged and not counted
      poke(205, 4'd3); poke(206, 4'd7);
      run_move(5, 5, 6, 5, 1'b0);
      chk("m5_ct", ct_l[2], 7);
      chk("m5_done", done_l[5], 1);
      chk("m5_pill", pill_count, 1);

      // ready held high long after done: one pulse, no re-entry
      curr_x = 6'd5; curr_y = 5'd5; next_x = 6'd5; next_y = 5'd5;
      ready = 1'b1; n_done = 0; n_rd = 0;
      for (int k = 0; k < 14; k++) begin
         step();
         n_done += int'(done); n_rd += int'(rd_addr != '0);
      end
      chk("m6_one_done", n_done, 1);
      chk("m6_one_rd", n_rd, 1);
      ready = 1'b0;
      step();
      ready = 1'b1; n_done = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         n_done += int'(done);
      end
      chk("m6_second_done", n_done, 1);
      ready = 1'b0;
      step(); step();

      // Reset during ERASE
      poke(820, 4'd3); poke(780, 4'd2);
      curr_x = 6'd20; curr_y = 5'd20; next_x = 6'd20; next_y = 5'd19;
      ready = 1'b1;
      for (int k = 0; k < 4; k++) step();
      chk("m7_in_erase", wr_en, 1);
      reset = 1'b1; ready = 1'b0;
      step();
      chk("m7_ct", collision_type, 0);
      chk("m7_done", done, 0);
      chk("m7_wen", wr_en, 0);
      chk("m7_waddr", wr_addr, 0);
      chk("m7_wdata", wr_data, 0);
      chk("m7_raddr", rd_addr, 0);
      chk("m7_pill", pill_count, 0);
      reset = 1'b0;
      step();
      chk("m7_idle", wr_en, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pacman_map_writer.md
# pacman_map_writer

Downstream partner of the pacman location controller. When the controller raises `ready` with a proposed next position, this block reads the map RAM tile at that position and returns it as `collision_type`. If the move is legal, it erases pacman from the current cell and draws him in the next cell, counts eaten pills, and pulses `done` so the controller commits the move. It owns the map RAM read and write ports for pacman moves.

## Interface
- `MAP_W`, default 40: map width in cells; legal x is 0..MAP_W-1.
- `MAP_H`, default 30: map height in cells; legal y is 0..MAP_H-1.
- `ADDR_W`, default 11: RAM address width; must hold MAP_W*MAP_H-1.
- `PILL_W`, default 33: pill counter width.
- `CLOCK_50`  in  1: clock; all logic on posedge.
- `reset`  in  1: synchronous, active-high.
- `ready`  in  1: controller has a move pending; `next_x`/`next_y` valid while high.
- `curr_x`  in  6: pacman current x.
- `curr_y`  in  5: pacman current y.
- `next_x`  in  6: proposed x.
- `next_y`  in  5: proposed y.
- `collision_type`  out  4: registered tile code at the proposed cell.
- `done`  out  1: one-cycle pulse; the move is resolved and the RAM is updated.
- `pill_count`  out  PILL_W: pills eaten since reset.
- `rd_addr`  out  ADDR_W: map RAM read address; the RAM has 1-cycle registered read latency.
- `rd_data`  in  4: map RAM read data.
- `wr_en`  out  1: map RAM write strobe.
- `wr_addr`  out  ADDR_W: map RAM write address.
- `wr_data`  out  4: map RAM write data.

## Operation
- Tile codes:
  - 0 EMPTY, 1 WALL, 2 PILL, 3 PACMAN.
  - Codes 4..15 are passable. They are reported unchanged and never counted.
- Address is y*MAP_W + x, truncated to ADDR_W bits. The multiply is done in ADDR_W-wide arithmetic.
- FSM states: IDLE, RD, RD_DATA, SETTLE, ERASE, DRAW, DONE, WAIT_LOW.
  - IDLE: if `ready`=1, go to RD.
  - RD: `rd_addr` = addr(next). Go to RD_DATA.
  - RD_DATA: register `collision_type`, then go to SETTLE.
    - If next_x ≥ MAP_W or next_y ≥ MAP_H, `collision_type` <= 1 (WALL); `rd_data` is ignored.
    - Otherwise `collision_type` <= `rd_data`.
  - SETTLE: one cycle that lets the controller recompute next.
    - If `collision_type`==1, or (next_x,next_y)==(curr_x,curr_y), go to DONE (no writes).
    - Otherwise go to ERASE.
  - ERASE: `wr_en`=1, `wr_addr`=addr(curr), `wr_data`=0. Go to DRAW.
  - DRAW: `wr_en`=1, `wr_addr`=addr(next), `wr_data`=3.
    - If `collision_type`==2, `pill_count` += 1. The counter wraps modulo 2^PILL_W.
    - Go to DONE.
  - DONE: `done`=1. Go to WAIT_LOW.
  - WAIT_LOW: `collision_type` <= 0. Stay until `ready`==0, then go to IDLE.
- `done`, `wr_en`, `wr_addr` and `wr_data` are decoded from state. `wr_addr`/`wr_data` are 0 when `wr_en`=0. `rd_addr` is 0 outside RD.
- `ready` dropping before DONE does not abort the sequence; the sequence completes.

## Timing
- Reset values: state IDLE, `collision_type`=0, `done`=0, `pill_count`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0.
- `reset` mid-sequence returns to IDLE on the next edge. A partially completed erase/draw is not undone.
- Latency, counting edge 0 as the edge at which `ready` is first sampled high in IDLE:
  - Legal move: `collision_type` valid after edge 2; ERASE cycle after edge 3; DRAW after edge 4; `done` high for the cycle after edge 5.
  - Wall or null move: `done` high for the cycle after edge 3; `wr_en` is never asserted.
- `done` is never high for two consecutive cycles.
- A new move is accepted no sooner than the first IDLE cycle with `ready`=1 after `ready` has been seen low in WAIT_LOW.
- `pill_count` updates at the edge ending DRAW, so it is visible in the same cycle as `done`.

## Test plan
- Reset, curr=(20,20), next=(20,19), RAM(20,19)=0, `ready` held high.
  - Expect `collision_type`=0, a write of 0 to addr 820, then a write of 3 to addr 780, `done` on cycle 6, `pill_count`=0.
- Same move with RAM(20,19)=2.
  - Expect the same writes and `pill_count`=1 in the `done` cycle.
- RAM(21,20)=1, next=(21,20); the bench drives next back to (20,20) after `collision_type`=1.
  - Expect no `wr_en`, `done` on cycle 4, and `collision_type` back to 0 after `ready` falls.
- next=(45,3), out of range.
  - Expect `collision_type`=1, no writes, `rd_data` ignored.
- `ready` held high for 10 cycles after `done`.
  - Expect exactly one `done` pulse and the FSM stuck in WAIT_LOW. Drop `ready` for 1 cycle and re-raise it: expect a second sequence.
- Assert `reset` during ERASE.
  - Expect all outputs at reset values on the next cycle and `pill_count`=0.
